// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port, with a built-in
// full-frame clear sequencer. All write-port outputs are registered.
module framebuffer_write_arbiter #(
  parameter int unsigned BITS_PER_PIXEL    = 12,
  parameter int unsigned FRAMEBUFFER_DEPTH = 640*480
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Req0_Valid,
  input  logic [31:0]               i_Req0_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Req0_Data,
  output logic                      o_Req0_Ready,
  input  logic                      i_Req1_Valid,
  input  logic [31:0]               i_Req1_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Req1_Data,
  output logic                      o_Req1_Ready,
  input  logic                      i_Clear_Start,
  input  logic [BITS_PER_PIXEL-1:0] i_Clear_Color,
  output logic                      o_Clear_Busy,
  output logic                      o_Clear_Done,
  output logic                      o_Addr_Error,
  output logic                      o_Write_Enable,
  output logic [31:0]               o_Write_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Write_Data
);

  localparam logic [31:0] DEPTH    = 32'(FRAMEBUFFER_DEPTH);
  localparam logic [31:0] LAST_IDX = DEPTH - 32'd1;

  typedef enum logic {s_ARBITRATE, s_CLEAR} state_t;

  state_t                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic [31:0]               index_q, index_d;
  logic [BITS_PER_PIXEL-1:0] color_q, color_d;
  logic                      we_q, we_d;
  logic [31:0]               addr_q, addr_d;
  logic [BITS_PER_PIXEL-1:0] data_q, data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      grant;
  logic                      ready0, ready1;
  logic [31:0]               sel_addr;
  logic [BITS_PER_PIXEL-1:0] sel_data;

  // Under contention the requester not served last wins.
  always_comb begin
    grant = 1'b0;
    if (i_Req0_Valid && i_Req1_Valid) grant = ~last_grant_q;
    else if (i_Req1_Valid)            grant = 1'b1;
  end

  assign ready0   = (state_q == s_ARBITRATE) && i_Req0_Valid && !grant && !i_Clear_Start;
  assign ready1   = (state_q == s_ARBITRATE) && i_Req1_Valid &&  grant && !i_Clear_Start;
  assign sel_addr = ready1 ? i_Req1_Addr : i_Req0_Addr;
  assign sel_data = ready1 ? i_Req1_Data : i_Req0_Data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    index_d      = index_q;
    color_d      = color_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    if (state_q == s_CLEAR) begin
      we_d    = 1'b1;
      addr_d  = index_q;
      data_d  = color_q;
      index_d = index_q + 32'd1;
      if (index_q == LAST_IDX) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = s_ARBITRATE;
      end
    end else begin
      if (i_Clear_Start) begin
        state_d = s_CLEAR;
        color_d = i_Clear_Color;
        index_d = '0;
        busy_d  = 1'b1;
      end else if (ready0 || ready1) begin
        // Out-of-range addresses are consumed without a write strobe.
        addr_d       = sel_addr;
        data_d       = sel_data;
        we_d         = (sel_addr < DEPTH);
        err_d        = err_q | (sel_addr >= DEPTH);
        last_grant_d = ready1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= s_ARBITRATE;
      last_grant_q <= 1'b1;
      index_q      <= '0;
      color_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      index_q      <= index_d;
      color_q      <= color_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign o_Req0_Ready   = ready0;
  assign o_Req1_Ready   = ready1;
  assign o_Clear_Busy   = busy_q;
  assign o_Clear_Done   = done_q;
  assign o_Addr_Error   = err_q;
  assign o_Write_Enable = we_q;
  assign o_Write_Addr   = addr_q;
  assign o_Write_Data   = data_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Bench for framebuffer_write_arbiter: vector table, directed clear/reset
// sequences and random traffic against a cycle-level reference model.
module tb_framebuffer_write_arbiter;

  localparam int BPP   = 12;
  localparam int DEPTH = 16;

  logic            clk;
  logic            i_Reset;
  logic            i_Req0_Valid, i_Req1_Valid;
  logic [31:0]     i_Req0_Addr, i_Req1_Addr;
  logic [BPP-1:0]  i_Req0_Data, i_Req1_Data;
  logic            o_Req0_Ready, o_Req1_Ready;
  logic            i_Clear_Start;
  logic [BPP-1:0]  i_Clear_Color;
  logic            o_Clear_Busy, o_Clear_Done, o_Addr_Error, o_Write_Enable;
  logic [31:0]     o_Write_Addr;
  logic [BPP-1:0]  o_Write_Data;

  framebuffer_write_arbiter #(
    .BITS_PER_PIXEL   (BPP),
    .FRAMEBUFFER_DEPTH(DEPTH)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (i_Reset),
    .i_Req0_Valid  (i_Req0_Valid),
    .i_Req0_Addr   (i_Req0_Addr),
    .i_Req0_Data   (i_Req0_Data),
    .o_Req0_Ready  (o_Req0_Ready),
    .i_Req1_Valid  (i_Req1_Valid),
    .i_Req1_Addr   (i_Req1_Addr),
    .i_Req1_Data   (i_Req1_Data),
    .o_Req1_Ready  (o_Req1_Ready),
    .i_Clear_Start (i_Clear_Start),
    .i_Clear_Color (i_Clear_Color),
    .o_Clear_Busy  (o_Clear_Busy),
    .o_Clear_Done  (o_Clear_Done),
    .o_Addr_Error  (o_Addr_Error),
    .o_Write_Enable(o_Write_Enable),
    .o_Write_Addr  (o_Write_Addr),
    .o_Write_Data  (o_Write_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who was served last, pixels left to clear, expected outputs.
  int             m_last  = 1;
  int             m_left  = 0;
  logic [BPP-1:0] m_color = '0;
  logic           e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [31:0]    e_addr = '0;
  logic [BPP-1:0] e_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check readies, advance model, check outputs.
  task automatic tick(input logic rst,
                      input logic v0, input logic [31:0] a0, input logic [BPP-1:0] d0,
                      input logic v1, input logic [31:0] a1, input logic [BPP-1:0] d1,
                      input logic cs, input logic [BPP-1:0] cc,
                      output logic r0, output logic r1);
    logic er0, er1;
    i_Reset = rst;
    i_Req0_Valid = v0; i_Req0_Addr = a0; i_Req0_Data = d0;
    i_Req1_Valid = v1; i_Req1_Addr = a1; i_Req1_Data = d1;
    i_Clear_Start = cs; i_Clear_Color = cc;
    #1;
    er0 = 0; er1 = 0;
    if (m_left == 0 && !cs) begin
      if (v0 && v1) begin
        if (m_last == 1) er0 = 1; else er1 = 1;
      end else if (v0) er0 = 1;
      else if (v1) er1 = 1;
    end
    check("ready0", o_Req0_Ready, er0);
    check("ready1", o_Req1_Ready, er1);
    r0 = o_Req0_Ready;
    r1 = o_Req1_Ready;

    e_done = 0;
    if (rst) begin
      e_we = 0; e_addr = 0; e_data = 0; e_busy = 0; e_err = 0;
      m_last = 1; m_left = 0;
    end else if (m_left > 0) begin
      e_we   = 1;
      e_addr = 32'(DEPTH - m_left);
      e_data = m_color;
      e_done = (m_left == 1);
      m_left--;
      e_busy = (m_left > 0);
    end else if (cs) begin
      m_color = cc; m_left = DEPTH; e_busy = 1; e_we = 0;
    end else if (er0 || er1) begin
      e_addr = er0 ? a0 : a1;
      e_data = er0 ? d0 : d1;
      e_we   = (e_addr < DEPTH);
      if (e_addr >= DEPTH) e_err = 1;
      m_last = er0 ? 0 : 1;
    end else begin
      e_we = 0;
    end

    @(posedge clk); #1;
    check("write_enable", o_Write_Enable, e_we);
    check("write_addr",   o_Write_Addr,   e_addr);
    check("write_data",   o_Write_Data,   e_data);
    check("clear_busy",   o_Clear_Busy,   e_busy);
    check("clear_done",   o_Clear_Done,   e_done);
    check("addr_error",   o_Addr_Error,   e_err);
  endtask

  task automatic idle(input logic rst);
    logic r0, r1;
    tick(rst, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  typedef struct {
    logic rst;
    logic v0; logic [31:0] a0; logic [BPP-1:0] d0;
    logic v1; logic [31:0] a1; logic [BPP-1:0] d1;
    logic er0; logic er1; logic ewe;
    logic [31:0] eaddr; logic [BPP-1:0] edata; logic eerr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic r0, r1;
    int busy_cnt, done_cnt, n;
    logic [31:0] done_addr;
    logic served;
    logic p0, p1, rst, cs;
    logic [31:0] ra0, ra1;
    logic [BPP-1:0] rd0, rd1, rcc;

    i_Reset = 1; i_Req0_Valid = 0; i_Req0_Addr = 0; i_Req0_Data = 0;
    i_Req1_Valid = 0; i_Req1_Addr = 0; i_Req1_Data = 0;
    i_Clear_Start = 0; i_Clear_Color = 0;
    @(posedge clk); #1;

    //          rst v0 a0   d0      v1 a1 d1      er0 er1 we addr data   err
    tbl[0]  = '{1, 0, 0,  12'h000, 0, 0, 12'h000, 0, 0, 0, 0,  12'h000, 0};
    tbl[1]  = '{0, 1, 5,  12'hABC, 0, 0, 12'h000, 1, 0, 1, 5,  12'hABC, 0};
    tbl[2]  = '{1, 0, 0,  12'h000, 0, 0, 12'h000, 0, 0, 0, 0,  12'h000, 0};
    tbl[3]  = '{0, 1, 1,  12'h111, 1, 2, 12'h222, 1, 0, 1, 1,  12'h111, 0};
    tbl[4]  = '{0, 1, 3,  12'h333, 1, 2, 12'h222, 0, 1, 1, 2,  12'h222, 0};
    tbl[5]  = '{0, 1, 3,  12'h333, 1, 4, 12'h444, 1, 0, 1, 3,  12'h333, 0};
    tbl[6]  = '{0, 1, 5,  12'h555, 1, 4, 12'h444, 0, 1, 1, 4,  12'h444, 0};
    tbl[7]  = '{0, 1, 5,  12'h555, 1, 6, 12'h666, 1, 0, 1, 5,  12'h555, 0};
    tbl[8]  = '{0, 1, 7,  12'h777, 1, 6, 12'h666, 0, 1, 1, 6,  12'h666, 0};
    tbl[9]  = '{0, 0, 0,  12'h000, 0, 0, 12'h000, 0, 0, 0, 6,  12'h666, 0};
    tbl[10] = '{0, 1, 16, 12'h123, 0, 0, 12'h000, 1, 0, 0, 16, 12'h123, 1};
    tbl[11] = '{0, 0, 0,  12'h000, 0, 0, 12'h000, 0, 0, 0, 16, 12'h123, 1};
    tbl[12] = '{1, 0, 0,  12'h000, 0, 0, 12'h000, 0, 0, 0, 0,  12'h000, 0};
    tbl[13] = '{0, 1, 15, 12'hFFF, 0, 0, 12'h000, 1, 0, 1, 15, 12'hFFF, 0};

    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
           0, 0, r0, r1);
      check("tbl_ready0", r0, tbl[i].er0);
      check("tbl_ready1", r1, tbl[i].er1);
      check("tbl_we",     o_Write_Enable, tbl[i].ewe);
      check("tbl_addr",   o_Write_Addr,   tbl[i].eaddr);
      check("tbl_data",   o_Write_Data,   tbl[i].edata);
      check("tbl_err",    o_Addr_Error,   tbl[i].eerr);
    end

    // Full clear with a request stalled behind it.
    tick(0, 0, 0, 0, 0, 0, 0, 1, 12'h00F, r0, r1);
    busy_cnt = o_Clear_Busy ? 1 : 0;
    done_cnt = 0; done_addr = '1; served = 0;
    for (int k = 0; k < 40 && !served; k++) begin
      tick(0, 1, 9, 12'hAAA, 0, 0, 0, 0, 0, r0, r1);
      if (r0) served = 1;
      if (o_Clear_Busy) busy_cnt++;
      if (o_Clear_Done) begin done_cnt++; done_addr = o_Write_Addr; end
    end
    check("clr_busy_cycles", busy_cnt, 16);
    check("clr_done_count",  done_cnt, 1);
    check("clr_done_addr",   done_addr, 15);
    check("clr_req_served",  served, 1);
    check("clr_req_write",   o_Write_Addr, 9);

    // Clear start beats a same-cycle request; request served right after.
    tick(0, 0, 0, 0, 1, 3, 12'h444, 1, 12'h0F0, r0, r1);
    check("clr_beats_req1", r1, 0);
    n = 0; served = 0;
    for (int k = 1; k < 40 && !served; k++) begin
      tick(0, 0, 0, 0, 1, 3, 12'h444, 0, 0, r0, r1);
      if (r1) begin served = 1; n = k; end
    end
    check("req1_after_clear", n, 17);

    // Reset in the middle of a clear, then restart.
    tick(0, 0, 0, 0, 0, 0, 0, 1, 12'h7E7, r0, r1);
    for (int k = 0; k < 7; k++) idle(0);
    check("mid_clear_addr", o_Write_Addr, 6);
    idle(1);
    check("abort_we",   o_Write_Enable, 0);
    check("abort_busy", o_Clear_Busy, 0);
    check("abort_done", o_Clear_Done, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 12'h111, r0, r1);
    idle(0);
    check("restart_addr", o_Write_Addr, 0);
    check("restart_we",   o_Write_Enable, 1);
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      idle(0);
      if (o_Clear_Done) done_cnt++;
    end
    check("restart_done_count", done_cnt, 1);

    // Random traffic; requests held until accepted.
    p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; ra0 = 32'($urandom_range(0, DEPTH + 3)); rd0 = BPP'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; ra1 = 32'($urandom_range(0, DEPTH + 3)); rd1 = BPP'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      cs  = ($urandom_range(0, 39) == 0);
      rcc = BPP'($urandom);
      tick(rst, p0, ra0, rd0, p1, ra1, rd1, cs, rcc, r0, r1);
      if (r0 && !rst) p0 = 0;
      if (r1 && !rst) p1 = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
